seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 149 ++++++++++++++
 tb/tb_seg7_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Eight-digit multiplexed seven-segment scanner. A prescaler
//                steps a digit index every DIV cycles; writes are buffered
//                and only take effect at a frame boundary, so a frame never
//                shows a mix of old and new values. Optional leading-zero
//                blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        blank_lz,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g,
  output logic [31:0] disp_value,
  output logic        frame_done
);

  // Prescaler width; DIV is at least 2 so $clog2 is at least 1.
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);

  // Registered state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      pending_q, pending_d;
  logic             pend_v_q, pend_v_d;
  logic [7:0]       num_csn_q, num_csn_d;
  logic [6:0]       num_a_g_q, num_a_g_d;
  logic             frame_done_q, frame_done_d;

  // Combinational helpers
  logic             tick;
  logic             boundary;
  logic [3:0]       cur_nibble;
  logic [2:0]       msnz;
  logic             blank_digit;

  // Hex nibble to active-high segment pattern, bit6=a ... bit0=g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h7e;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6d;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5b;
      4'h6:    seg = 7'h5f;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7f;
      4'h9:    seg = 7'h7b;
      4'ha:    seg = 7'h77;
      4'hb:    seg = 7'h1f;
      4'hc:    seg = 7'h4e;
      4'hd:    seg = 7'h3d;
      4'he:    seg = 7'h4f;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  // Prescaler and digit index: tick on the last prescaler count, frame
  // boundary on the tick that leaves digit 7.
  always_comb begin
    tick     = (cnt_q == C_CNT_LAST);
    boundary = tick && (idx_q == 3'd7);
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
  end

  // Write buffering: a write landing on the boundary cycle bypasses the
  // pending register so the newest value wins; otherwise the pending value
  // is promoted at the boundary.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (boundary && wr_en) begin
      shadow_d = wr_data;
      pend_v_d = 1'b0;
    end else if (boundary && pend_v_q) begin
      shadow_d = pending_q;
      pend_v_d = 1'b0;
    end else if (wr_en) begin
      pending_d = wr_data;
      pend_v_d  = 1'b1;
    end
  end

  // Most-significant nonzero nibble; stays 0 for an all-zero shadow so
  // digit 0 is never blanked.
  always_comb begin
    msnz = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (shadow_q[4*k +: 4] != 4'd0) begin
        msnz = 3'(k);
      end
    end
  end

  // Output stage inputs: digit select, decoded segments with blanking,
  // and the frame pulse.
  always_comb begin
    cur_nibble   = shadow_q[{idx_q, 2'b00} +: 4];
    blank_digit  = blank_lz && (idx_q > msnz);
    num_csn_d    = ~(8'b0000_0001 << idx_q);
    num_a_g_d    = blank_digit ? 7'h00 : seg_decode(cur_nibble);
    frame_done_d = boundary;
  end

  // State and output registers with synchronous active-low reset; reset
  // takes priority over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= 32'd0;
      pending_q    <= 32'd0;
      pend_v_q     <= 1'b0;
      num_csn_q    <= 8'hff;
      num_a_g_q    <= 7'h00;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      num_csn_q    <= num_csn_d;
      num_a_g_q    <= num_a_g_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign num_csn    = num_csn_q;
  assign num_a_g    = num_a_g_q;
  assign frame_done = frame_done_q;
  assign disp_value = shadow_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan
//  Description : Self-checking bench for seg7_scan (DIV=4) against a
//                cycle-count based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  localparam logic [6:0] SEG [16] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
                                      7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        blank_lz = 1'b0;
  logic [7:0]  num_csn;
  logic [6:0]  num_a_g;
  logic [31:0] disp_value;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: cycles since reset release, shown value, and the
  // newest write received since the last frame boundary.
  int          m_n = 0;
  logic [31:0] m_shadow = 32'd0;
  logic [31:0] m_latest = 32'd0;
  bit          m_latest_v = 1'b0;
  logic        cur_blz = 1'b0;

  logic [6:0]  seen_seg [8];
  logic [31:0] watch_val = 32'd0;
  bit          watch_hit = 1'b0;

  seg7_scan #(.DIV(DIV)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .blank_lz  (blank_lz),
    .num_csn   (num_csn),
    .num_a_g   (num_a_g),
    .disp_value(disp_value),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] nib(input logic [31:0] v, input int k);
    return 4'((v >> (4 * k)) & 32'hf);
  endfunction

  function automatic int top_digit(input logic [31:0] v);
    int t = 0;
    for (int k = 0; k < 8; k++) if (nib(v, k) != 4'd0) t = k;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic rn, input logic we, input logic [31:0] wd, input logic blz);
    logic [7:0] e_csn;
    logic [6:0] e_seg;
    logic       e_fd;
    int         dig;
    bit         bnd;
    resetn = rn; wr_en = we; wr_data = wd; blank_lz = blz;
    dig = 0;
    if (!rn) begin
      e_csn = 8'hff; e_seg = 7'h00; e_fd = 1'b0;
      m_n = 0; m_shadow = 32'd0; m_latest_v = 1'b0;
    end else begin
      dig   = (m_n / DIV) % 8;
      bnd   = (m_n % FRAME) == FRAME - 1;
      e_csn = ~(8'd1 << dig);
      e_seg = (blz && dig > top_digit(m_shadow)) ? 7'h00 : SEG[nib(m_shadow, dig)];
      e_fd  = bnd;
      if (we) begin m_latest = wd; m_latest_v = 1'b1; end
      if (bnd && m_latest_v) begin m_shadow = m_latest; m_latest_v = 1'b0; end
      m_n++;
    end
    @(posedge clk);
    #1;
    check("num_csn", 32'(num_csn), 32'(e_csn));
    check("num_a_g", 32'(num_a_g), 32'(e_seg));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("disp_value", disp_value, m_shadow);
    if (rn) seen_seg[dig] = num_a_g;
    if (disp_value === watch_val) watch_hit = 1'b1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 32'd0, cur_blz);
  endtask

  // Advance until the next step will be taken at digit dig, prescaler phase ph.
  task automatic to_phase(input int dig, input int ph);
    int guard = 0;
    while (!(((m_n / DIV) % 8) == dig && (m_n % DIV) == ph) && guard <= FRAME) begin
      step(1'b1, 1'b0, 32'd0, cur_blz);
      guard++;
    end
    if (guard > FRAME) check("to_phase_bound", 32'(guard), 32'(FRAME));
  endtask

  // Cross the next frame boundary, then scan one full frame.
  task automatic next_frame();
    to_phase(7, DIV - 1);
    idle(1 + FRAME);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0);
    check("reset_csn", 32'(num_csn), 32'h0000_00ff);
    check("reset_seg", 32'(num_a_g), 32'h0000_0000);
    step(1'b0, 1'b0, 32'd0, 1'b0);

    // Release: first cycle shows digit 0 as "0"
    step(1'b1, 1'b0, 32'd0, 1'b0);
    check("release_csn", 32'(num_csn), 32'h0000_00fe);
    check("release_seg", 32'(num_a_g), 32'h0000_007e);
    idle(2 * FRAME + 3);

    // Decode table
    to_phase(2, 1);
    step(1'b1, 1'b1, 32'h89AB_CDEF, cur_blz);
    next_frame();
    check("tbl_d0", 32'(seen_seg[0]), 32'h47);
    check("tbl_d3", 32'(seen_seg[3]), 32'h4e);
    check("tbl_d7", 32'(seen_seg[7]), 32'h7f);
    check("tbl_disp", disp_value, 32'h89AB_CDEF);

    // Back-to-back writes in one frame: only the last survives
    watch_val = 32'h1; watch_hit = 1'b0;
    to_phase(3, 0);
    step(1'b1, 1'b1, 32'h1, cur_blz);
    to_phase(5, 0);
    step(1'b1, 1'b1, 32'h2, cur_blz);
    check("midframe_hold", disp_value, 32'h89AB_CDEF);
    next_frame();
    check("midframe_disp", disp_value, 32'h2);
    check("midframe_never1", 32'(watch_hit), 32'h0);

    // Write coinciding with the boundary beats an older pending write
    to_phase(4, 0);
    step(1'b1, 1'b1, 32'h7, cur_blz);
    to_phase(7, DIV - 1);
    step(1'b1, 1'b1, 32'h5, cur_blz);
    check("simul_disp", disp_value, 32'h5);
    idle(FRAME + 2);
    check("simul_nopend", disp_value, 32'h5);

    // Leading-zero blanking
    to_phase(1, 2);
    step(1'b1, 1'b1, 32'h0000_0A30, cur_blz);
    cur_blz = 1'b1;
    next_frame();
    for (int k = 3; k < 8; k++) check("blank_on_hi", 32'(seen_seg[k]), 32'h00);
    check("blank_on_d2", 32'(seen_seg[2]), 32'h77);
    check("blank_on_d1", 32'(seen_seg[1]), 32'h79);
    check("blank_on_d0", 32'(seen_seg[0]), 32'h7e);
    cur_blz = 1'b0;
    idle(FRAME);
    for (int k = 3; k < 8; k++) check("blank_off_hi", 32'(seen_seg[k]), 32'h7e);

    // Reset mid-frame with a write pending
    watch_val = 32'h0000_DEAD; watch_hit = 1'b0;
    to_phase(2, 0);
    step(1'b1, 1'b1, 32'h0000_DEAD, cur_blz);
    to_phase(4, 1);
    step(1'b0, 1'b0, 32'd0, cur_blz);
    check("midrst_csn", 32'(num_csn), 32'h0000_00ff);
    check("midrst_seg", 32'(num_a_g), 32'h0000_0000);
    check("midrst_disp", disp_value, 32'h0);
    idle(2 * FRAME + 4);
    check("midrst_never_pend", 32'(watch_hit), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic rn;
      logic we;
      rn = ($urandom_range(0, 199) != 0);
      we = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) cur_blz = ~cur_blz;
      step(rn, we, (($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0fff) : $urandom), cur_blz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
